alu_rsv_station: RTL and testbench

// - Integer reservation station directly upstream of the ALU execution unit.
// - Buffers dispatched ALU, branch and jump micro-ops until both operands are valid.
// - Snoops the common data bus (CDB) to capture operand results as they are produced.
// - Issues one ready entry per cycle to the ALU via registered outputs.

---
 rtl/alu_rsv_station.sv | 164 ++++++++++++++++
 tb/tb_alu_rsv_station.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rsv_station.sv
// Integer reservation station feeding the ALU: holds micro-ops until operands arrive via CDB.
// Optional build macro RS_FLUSH_EN adds a flush input that empties the station.
module alu_rsv_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int XLEN  = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef RS_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [XLEN-1:0]  disp_op1,
    input  logic [TAG_W-1:0] disp_op1_tag,
    input  logic             disp_op1_rdy,
    input  logic [XLEN-1:0]  disp_op2,
    input  logic [TAG_W-1:0] disp_op2_tag,
    input  logic             disp_op2_rdy,
    input  logic [2:0]       disp_alu_ext,
    input  logic [2:0]       disp_funct3,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             iss_valid,
    output logic [XLEN-1:0]  iss_op1,
    output logic [XLEN-1:0]  iss_op2,
    output logic [2:0]       iss_alu_ext,
    output logic [2:0]       iss_funct3,
    output logic [TAG_W-1:0] iss_tag,
    output logic [CW-1:0]    rs_count
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] op1_rdy;
    logic [DEPTH-1:0] op2_rdy;
    logic [XLEN-1:0]  op1     [DEPTH];
    logic [XLEN-1:0]  op2     [DEPTH];
    logic [TAG_W-1:0] op1_tag [DEPTH];
    logic [TAG_W-1:0] op2_tag [DEPTH];
    logic [TAG_W-1:0] dst_tag [DEPTH];
    logic [2:0]       alu_ext [DEPTH];
    logic [2:0]       funct3  [DEPTH];

    logic          flush_now;
    logic          has_free;
    logic          has_sel;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] sel_idx;
    logic [CW-1:0] count;
    logic          disp_fire;
    logic          byp1;
    logic          byp2;

`ifdef RS_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Free slot and issue pick both look only at registered state, lowest index first.
    always_comb begin
        has_free = 1'b0;
        has_sel  = 1'b0;
        free_idx = '0;
        sel_idx  = '0;
        count    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
            if (valid[i] && op1_rdy[i] && op2_rdy[i]) begin
                has_sel = 1'b1;
                sel_idx = IW'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(valid[i]);
        end
    end

    assign rs_count   = count;
    assign disp_ready = (count != CW'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready && has_free;
    assign byp1 = cdb_valid && !disp_op1_rdy && (cdb_tag == disp_op1_tag);
    assign byp2 = cdb_valid && !disp_op2_rdy && (cdb_tag == disp_op2_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            op1_rdy <= '0;
            op2_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op1[i]     <= '0;
                op2[i]     <= '0;
                op1_tag[i] <= '0;
                op2_tag[i] <= '0;
                dst_tag[i] <= '0;
                alu_ext[i] <= '0;
                funct3[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && cdb_valid) begin
                    if (!op1_rdy[i] && op1_tag[i] == cdb_tag) begin
                        op1[i]     <= cdb_data;
                        op1_rdy[i] <= 1'b1;
                    end
                    if (!op2_rdy[i] && op2_tag[i] == cdb_tag) begin
                        op2[i]     <= cdb_data;
                        op2_rdy[i] <= 1'b1;
                    end
                end
            end
            if (has_sel) begin
                valid[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                valid[free_idx]   <= 1'b1;
                op1[free_idx]     <= byp1 ? cdb_data : disp_op1;
                op1_rdy[free_idx] <= disp_op1_rdy || byp1;
                op1_tag[free_idx] <= disp_op1_tag;
                op2[free_idx]     <= byp2 ? cdb_data : disp_op2;
                op2_rdy[free_idx] <= disp_op2_rdy || byp2;
                op2_tag[free_idx] <= disp_op2_tag;
                dst_tag[free_idx] <= disp_tag;
                alu_ext[free_idx] <= disp_alu_ext;
                funct3[free_idx]  <= disp_funct3;
            end
            if (flush_now) begin
                valid <= '0;
            end
        end
    end

    // Issue registers: data fields hold when nothing issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid   <= 1'b0;
            iss_op1     <= '0;
            iss_op2     <= '0;
            iss_alu_ext <= '0;
            iss_funct3  <= '0;
            iss_tag     <= '0;
        end else if (flush_now) begin
            iss_valid <= 1'b0;
        end else if (has_sel) begin
            iss_valid   <= 1'b1;
            iss_op1     <= op1[sel_idx];
            iss_op2     <= op2[sel_idx];
            iss_alu_ext <= alu_ext[sel_idx];
            iss_funct3  <= funct3[sel_idx];
            iss_tag     <= dst_tag[sel_idx];
        end else begin
            iss_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Self-checking bench for alu_rsv_station: directed scenarios plus random traffic
// compared against an entry-list reference model.
module tb_alu_rsv_station;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
`ifdef RS_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        dv = 1'b0;
    logic        disp_ready;
    logic [31:0] a_val = '0;
    logic [5:0]  a_tag = '0;
    logic        a_rdy = 1'b0;
    logic [31:0] b_val = '0;
    logic [5:0]  b_tag = '0;
    logic        b_rdy = 1'b0;
    logic [2:0]  ext = '0;
    logic [2:0]  f3 = '0;
    logic [5:0]  dtag = '0;
    logic        cv = 1'b0;
    logic [5:0]  ctag = '0;
    logic [31:0] cdata = '0;
    logic        iss_valid;
    logic [31:0] iss_op1;
    logic [31:0] iss_op2;
    logic [2:0]  iss_alu_ext;
    logic [2:0]  iss_funct3;
    logic [5:0]  iss_tag;
    logic [2:0]  rs_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_rsv_station #(.DEPTH(DEPTH), .TAG_W(6), .XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef RS_FLUSH_EN
        .flush(flush),
`endif
        .disp_valid(dv),
        .disp_ready(disp_ready),
        .disp_op1(a_val),
        .disp_op1_tag(a_tag),
        .disp_op1_rdy(a_rdy),
        .disp_op2(b_val),
        .disp_op2_tag(b_tag),
        .disp_op2_rdy(b_rdy),
        .disp_alu_ext(ext),
        .disp_funct3(f3),
        .disp_tag(dtag),
        .cdb_valid(cv),
        .cdb_tag(ctag),
        .cdb_data(cdata),
        .iss_valid(iss_valid),
        .iss_op1(iss_op1),
        .iss_op2(iss_op2),
        .iss_alu_ext(iss_alu_ext),
        .iss_funct3(iss_funct3),
        .iss_tag(iss_tag),
        .rs_count(rs_count)
    );

    typedef struct {
        bit          v;
        logic [31:0] o1;
        logic [5:0]  t1;
        bit          r1;
        logic [31:0] o2;
        logic [5:0]  t2;
        bit          r2;
        logic [2:0]  ext;
        logic [2:0]  f3;
        logic [5:0]  tag;
    } ent_t;

    ent_t        m [DEPTH];
    bit          e_valid;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [2:0]  e_ext;
    logic [2:0]  e_f3;
    logic [5:0]  e_tag;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i].v = 0;
        e_valid = 0;
        e_op1 = '0;
        e_op2 = '0;
        e_ext = '0;
        e_f3 = '0;
        e_tag = '0;
    endtask

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m[i].v) n++;
        return n;
    endfunction

    // One clock edge: oldest-state issue, then CDB wakeup, then dispatch.
    task automatic model_step();
        int s = -1;
        int f = -1;
        int n = occupancy();
        for (int i = 0; i < DEPTH; i++) begin
            if (s < 0 && m[i].v && m[i].r1 && m[i].r2) s = i;
            if (f < 0 && !m[i].v) f = i;
        end
        e_valid = (s >= 0);
        if (s >= 0) begin
            e_op1 = m[s].o1;
            e_op2 = m[s].o2;
            e_ext = m[s].ext;
            e_f3 = m[s].f3;
            e_tag = m[s].tag;
            m[s].v = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v && cv) begin
                if (!m[i].r1 && m[i].t1 == ctag) begin
                    m[i].o1 = cdata;
                    m[i].r1 = 1;
                end
                if (!m[i].r2 && m[i].t2 == ctag) begin
                    m[i].o2 = cdata;
                    m[i].r2 = 1;
                end
            end
        end
        if (dv && n < DEPTH) begin
            m[f].v = 1;
            m[f].t1 = a_tag;
            m[f].t2 = b_tag;
            m[f].r1 = a_rdy || (cv && ctag == a_tag);
            m[f].r2 = b_rdy || (cv && ctag == b_tag);
            m[f].o1 = (!a_rdy && cv && ctag == a_tag) ? cdata : a_val;
            m[f].o2 = (!b_rdy && cv && ctag == b_tag) ? cdata : b_val;
            m[f].ext = ext;
            m[f].f3 = f3;
            m[f].tag = dtag;
        end
    endtask

    task automatic check_model();
        chk("rs_count", 64'(rs_count), 64'(occupancy()));
        chk("disp_ready", 64'(disp_ready), 64'(occupancy() < DEPTH));
        chk("iss_valid", 64'(iss_valid), 64'(e_valid));
        chk("iss_op1", 64'(iss_op1), 64'(e_op1));
        chk("iss_op2", 64'(iss_op2), 64'(e_op2));
        chk("iss_alu_ext", 64'(iss_alu_ext), 64'(e_ext));
        chk("iss_funct3", 64'(iss_funct3), 64'(e_f3));
        chk("iss_tag", 64'(iss_tag), 64'(e_tag));
    endtask

    // Drive one cycle of inputs (called just after a negedge), clock it, then compare.
    task automatic tick(input bit d, input logic [31:0] av, input logic [5:0] at,
                        input bit ar, input logic [31:0] bv, input logic [5:0] bt,
                        input bit br, input logic [5:0] tg, input bit c,
                        input logic [5:0] ct, input logic [31:0] cd);
        dv = d;
        a_val = av;
        a_tag = at;
        a_rdy = ar;
        b_val = bv;
        b_tag = bt;
        b_rdy = br;
        ext = tg[2:0];
        f3 = tg[5:3];
        dtag = tg;
        cv = c;
        ctag = ct;
        cdata = cd;
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wake(input logic [5:0] t, input logic [31:0] d);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, t, d);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_count", 64'(rs_count), 64'd0);
        chk("reset_ready", 64'(disp_ready), 64'd1);
        rst_n = 1'b1;

        // T1: both operands ready
        tick(1, 5, 0, 1, 7, 0, 1, 3, 0, 0, 0);
        chk("t1_not_yet", 64'(iss_valid), 64'd0);
        idle();
        chk("t1_valid", 64'(iss_valid), 64'd1);
        chk("t1_op1", 64'(iss_op1), 64'd5);
        chk("t1_op2", 64'(iss_op2), 64'd7);
        chk("t1_tag", 64'(iss_tag), 64'd3);
        chk("t1_count", 64'(rs_count), 64'd0);

        // T2: op1 woken by CDB
        tick(1, 0, 9, 0, 2, 0, 1, 4, 0, 0, 0);
        idle();
        wake(9, 40);
        chk("t2_wait", 64'(iss_valid), 64'd0);
        idle();
        chk("t2_valid", 64'(iss_valid), 64'd1);
        chk("t2_op1", 64'(iss_op1), 64'd40);
        chk("t2_op2", 64'(iss_op2), 64'd2);

        // T3: dispatch-time bypass
        tick(1, 1, 0, 1, 0, 12, 0, 5, 1, 12, 32'hDEAD);
        idle();
        chk("t3_valid", 64'(iss_valid), 64'd1);
        chk("t3_op2", 64'(iss_op2), 64'hDEAD);

        // T4: fill, refuse, wake entry 2
        for (int i = 0; i < 4; i++) tick(1, 0, 6'(20 + i), 0, 1, 0, 1, 6'(40 + i), 0, 0, 0);
        chk("t4_full_ready", 64'(disp_ready), 64'd0);
        chk("t4_full_count", 64'(rs_count), 64'd4);
        tick(1, 0, 33, 0, 1, 0, 1, 44, 0, 0, 0);
        chk("t4_refused", 64'(rs_count), 64'd4);
        wake(22, 100);
        idle();
        chk("t4_iss_tag", 64'(iss_tag), 64'd42);
        chk("t4_ready_again", 64'(disp_ready), 64'd1);
        wake(20, 1);
        wake(21, 2);
        wake(23, 3);
        repeat (3) idle();
        chk("t4_drained", 64'(rs_count), 64'd0);

        // T5: same tag wakes entries 1 and 3
        tick(1, 0, 30, 0, 9, 0, 1, 50, 0, 0, 0);
        tick(1, 0, 31, 0, 9, 0, 1, 51, 0, 0, 0);
        tick(1, 0, 32, 0, 9, 0, 1, 52, 0, 0, 0);
        tick(1, 0, 31, 0, 9, 0, 1, 53, 0, 0, 0);
        wake(31, 77);
        idle();
        chk("t5_first", 64'(iss_tag), 64'd51);
        idle();
        chk("t5_second", 64'(iss_tag), 64'd53);
        chk("t5_second_op1", 64'(iss_op1), 64'd77);
        wake(30, 0);
        wake(32, 0);
        repeat (3) idle();

        // Random traffic over a small tag space
        for (int n = 0; n < 1500; n++) begin
            tick($urandom_range(0, 3) != 0, $urandom, 6'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0, $urandom, 6'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0, 6'($urandom), $urandom_range(0, 1) == 1,
                 6'($urandom_range(0, 7)), $urandom);
        end
        repeat (6) wake(6'($urandom_range(0, 7)), $urandom);

        // T6: async reset while issuing
        tick(1, 11, 0, 1, 12, 0, 1, 7, 0, 0, 0);
        tick(1, 13, 0, 1, 14, 0, 1, 8, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_iss_valid", 64'(iss_valid), 64'd0);
        chk("t6_count", 64'(rs_count), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        chk("t6_no_stale", 64'(iss_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
